// File: rtl/snow64_issue_scheduler_pkg.sv
// snow64_issue_scheduler_pkg: decoded-instruction layout, unit/state encodings and register-usage types
package snow64_issue_scheduler_pkg;
  typedef struct packed {
    logic [2:0]  group;
    logic        op_type;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [3:0]  oper;
    logic [63:0] signext_imm;
    logic        nop;
  } decoded_t;
  typedef enum logic [1:0] {unit_alu, unit_cf, unit_mem, unit_io} issue_unit_t;
  localparam logic [0:0] st_run = 1'b0;
  localparam logic [0:0] st_br_wait = 1'b1;
  typedef struct packed {
    logic uses_ra_src;
    logic uses_rb;
    logic uses_rc;
    logic writes_ra;
    logic is_branch;
    logic illegal;
  } reg_usage_t;
  localparam logic [3:0] op_alu_inv = 4'd10;
  localparam logic [3:0] op_alu_add_pc_simm12 = 4'd12;
  localparam logic [3:0] op_cf_jmp = 4'd2;
  localparam logic [3:0] op_cf_reti = 4'd5;
  localparam logic [3:0] op_cf_cpy_reg_ie = 4'd6;
  localparam logic [3:0] op_cf_cpy_reg_idsta = 4'd8;
  localparam logic [3:0] op_cf_cpy_ie_reg = 4'd9;
  localparam logic [3:0] op_cf_cpy_idsta_reg = 4'd11;
  localparam logic [3:0] op_ldst_io_last = 4'd8;
  localparam logic [3:0] op_io_out = 4'd8;
  function automatic issue_unit_t unit_of(input logic [2:0] group);
    return group == 3'd0 ? unit_alu : group == 3'd1 ? unit_cf : group == 3'd4 ? unit_io : unit_mem;
  endfunction
endpackage

// File: rtl/snow64_reg_usage_decode.sv
// snow64_reg_usage_decode: combinational group/oper to register-usage and legality
module snow64_reg_usage_decode
  import snow64_issue_scheduler_pkg::*;
(
  input  logic [2:0]  group,
  input  logic [3:0]  oper,
  output reg_usage_t  usage
);
  logic g0, g1, g2, g3, g4, bad, cf_br, cf_src, cf_dst;
  assign g0 = group == 3'd0;
  assign g1 = group == 3'd1;
  assign g2 = group == 3'd2;
  assign g3 = group == 3'd3;
  assign g4 = group == 3'd4;
  assign bad = group > 3'd4 || (g0 && oper > op_alu_add_pc_simm12) || (g1 && oper > op_cf_cpy_idsta_reg)
    || ((g2 || g3 || g4) && oper > op_ldst_io_last);
  assign cf_br = g1 && (oper <= op_cf_jmp || oper == op_cf_reti);
  assign cf_src = g1 && (oper <= op_cf_jmp || oper >= op_cf_cpy_ie_reg);
  assign cf_dst = g1 && oper >= op_cf_cpy_reg_ie && oper <= op_cf_cpy_reg_idsta;
  assign usage.illegal = bad;
  assign usage.is_branch = !bad && cf_br;
  assign usage.writes_ra = !bad && (g0 || g2 || (g4 && oper != op_io_out) || cf_dst);
  assign usage.uses_ra_src = !bad && (g3 || (g4 && oper == op_io_out) || cf_src);
  assign usage.uses_rb = !bad && ((g0 && oper != op_alu_add_pc_simm12) || g2 || g3 || g4);
  assign usage.uses_rc = !bad && ((g0 && oper < op_alu_inv) || g2 || g3);
endmodule

// File: rtl/snow64_issue_scheduler.sv
// snow64_issue_scheduler: single-issue scheduler with register scoreboard, unit routing and branch hold
module snow64_issue_scheduler
  import snow64_issue_scheduler_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  decoded_t            in_decoded,
  output decoded_t            out_decoded,
  output logic                out_alu_valid,
  input  logic                out_alu_ready,
  output logic                out_cf_valid,
  input  logic                out_cf_ready,
  output logic                out_mem_valid,
  input  logic                out_mem_ready,
  output logic                out_io_valid,
  input  logic                out_io_ready,
  input  logic                wb_valid,
  input  logic [3:0]          wb_index,
  input  logic                br_done,
  output logic                illegal,
  output logic [NUM_REGS-1:0] sb_pending
);
  reg_usage_t usage;
  issue_unit_t slot_unit;
  logic slot_valid, hazard, sel_ready, handoff, accept, issue;
  logic [0:0] state;
  logic [NUM_REGS-1:0] sb_next;
  snow64_reg_usage_decode u_decode (
    .group(in_decoded.group),
    .oper(in_decoded.oper),
    .usage(usage)
  );
  assign hazard = !in_decoded.nop && (((usage.uses_ra_src || usage.writes_ra) && sb_pending[in_decoded.ra])
    || (usage.uses_rb && sb_pending[in_decoded.rb]) || (usage.uses_rc && sb_pending[in_decoded.rc]));
  assign sel_ready = slot_unit == unit_alu ? out_alu_ready : slot_unit == unit_cf ? out_cf_ready
    : slot_unit == unit_mem ? out_mem_ready : out_io_ready;
  assign handoff = slot_valid && sel_ready;
  assign in_ready = !rst && state == st_run && !hazard && (!slot_valid || handoff);
  assign accept = in_valid && in_ready;
  assign issue = accept && !in_decoded.nop && !usage.illegal;
  assign out_alu_valid = slot_valid && slot_unit == unit_alu;
  assign out_cf_valid = slot_valid && slot_unit == unit_cf;
  assign out_mem_valid = slot_valid && slot_unit == unit_mem;
  assign out_io_valid = slot_valid && slot_unit == unit_io;
  // writeback clear applies before the accept set, so a same-index collision leaves the bit set
  assign sb_next = (sb_pending & ~(wb_valid ? NUM_REGS'(1) << wb_index : '0))
    | (issue && usage.writes_ra ? NUM_REGS'(1) << in_decoded.ra : '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= st_run;
      slot_valid <= 1'b0;
      slot_unit <= unit_alu;
      out_decoded <= '0;
      illegal <= 1'b0;
      sb_pending <= '0;
    end else begin
      state <= state == st_run ? (issue && usage.is_branch ? st_br_wait : st_run) : (br_done ? st_run : st_br_wait);
      slot_valid <= issue ? 1'b1 : handoff ? 1'b0 : slot_valid;
      slot_unit <= issue ? unit_of(in_decoded.group) : slot_unit;
      out_decoded <= issue ? in_decoded : out_decoded;
      illegal <= accept && !in_decoded.nop && usage.illegal;
      sb_pending <= sb_next;
    end
  end
endmodule

// File: tb/tb_snow64_issue_scheduler.sv
// tb_snow64_issue_scheduler: scoreboard-driven bench for the issue scheduler
module tb_snow64_issue_scheduler;
  import snow64_issue_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, wb_valid, br_done, illegal;
  logic out_alu_valid, out_alu_ready, out_cf_valid, out_cf_ready;
  logic out_mem_valid, out_mem_ready, out_io_valid, out_io_ready;
  logic [3:0] wb_index;
  logic [15:0] sb_pending;
  decoded_t in_decoded, out_decoded;
  int vectors = 0;
  int miscompares = 0;
  decoded_t exp_q[$];
  logic hold_pending = 1'b0;
  decoded_t hold_dec;
  logic [3:0] hold_sel, valids, readies;

  snow64_issue_scheduler #(.NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_decoded(in_decoded),
    .out_decoded(out_decoded),
    .out_alu_valid(out_alu_valid), .out_alu_ready(out_alu_ready),
    .out_cf_valid(out_cf_valid), .out_cf_ready(out_cf_ready),
    .out_mem_valid(out_mem_valid), .out_mem_ready(out_mem_ready),
    .out_io_valid(out_io_valid), .out_io_ready(out_io_ready),
    .wb_valid(wb_valid), .wb_index(wb_index), .br_done(br_done),
    .illegal(illegal), .sb_pending(sb_pending)
  );

  initial forever #5 clk = ~clk;
  assign valids = {out_io_valid, out_mem_valid, out_cf_valid, out_alu_valid};
  assign readies = {out_io_ready, out_mem_ready, out_cf_ready, out_alu_ready};

  function automatic decoded_t mk(input logic [2:0] g, input logic [3:0] op, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic [3:0] rc, input logic nop = 1'b0);
    decoded_t d;
    d.group = g; d.op_type = 1'b0; d.ra = ra; d.rb = rb; d.rc = rc; d.oper = op;
    d.signext_imm = {$urandom, $urandom}; d.nop = nop;
    return d;
  endfunction

  function automatic logic tb_legal(input decoded_t d);
    return d.group <= 3'd4 && d.oper <= (d.group == 3'd0 ? 4'd12 : d.group == 3'd1 ? 4'd11 : 4'd8);
  endfunction

  function automatic logic [3:0] tb_sel(input logic [2:0] g);
    return g == 3'd0 ? 4'b0001 : g == 3'd1 ? 4'b0010 : g == 3'd4 ? 4'b1000 : 4'b0100;
  endfunction

  // monitor: one-hot valids, hold stability, and in-order issue against the expected queue
  initial forever begin
    decoded_t d;
    @(negedge clk);
    if (rst) hold_pending = 1'b0;
    else begin
      vectors++;
      if ($countones(valids) > 1) begin
        miscompares++; $display("FAIL onehot: valids=%b required at most one set", valids);
      end
      if (hold_pending) begin
        vectors++;
        if (valids !== hold_sel || out_decoded !== hold_dec) begin
          miscompares++; $display("FAIL hold: valids=%b dec=%h required valids=%b dec=%h", valids, out_decoded, hold_sel, hold_dec);
        end
      end
      hold_pending = 1'b0;
      if ((valids & readies) != 4'b0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL issue_unexpected: valids=%b dec=%h required no issue", valids, out_decoded);
        end else begin
          d = exp_q.pop_front();
          if (out_decoded !== d || valids !== tb_sel(d.group)) begin
            miscompares++; $display("FAIL issue: valids=%b dec=%h required valids=%b dec=%h", valids, out_decoded, tb_sel(d.group), d);
          end
        end
      end else if (valids != 4'b0) begin
        hold_pending = 1'b1; hold_dec = out_decoded; hold_sel = valids;
      end
      if (in_valid && in_ready && !in_decoded.nop && tb_legal(in_decoded)) exp_q.push_back(in_decoded);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input decoded_t d);
    in_valid = 1'b1; in_decoded = d; #1;
    for (int i = 0; i < 20 && !in_ready; i++) begin @(posedge clk); #2; end
    vectors++;
    if (!in_ready) begin
      miscompares++; $display("FAIL send_timeout: in_ready=%b required 1 within 20 cycles", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1; in_valid = 1'b0;
    end
  endtask

  task automatic wb(input logic [3:0] idx);
    wb_valid = 1'b1; wb_index = idx; tick(); wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    tick(); rst = 1'b0; #1;
    vectors++;
    if (valids !== 4'b0 || out_decoded !== '0 || illegal !== 1'b0 || sb_pending !== 16'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valids=%b dec=%h ill=%b sb=%h rdy=%b required 0,0,0,0,1", valids, out_decoded, illegal, sb_pending, in_ready);
    end
  endtask

  task automatic test_alu();
    decoded_t d = mk(3'd0, 4'd0, 4'd1, 4'd2, 4'd3);
    send(d);
    vectors++;
    if (valids !== 4'b0001 || sb_pending !== 16'h0002 || out_decoded !== d) begin
      miscompares++; $display("FAIL alu_issue: valids=%b sb=%h dec=%h required 0001 0002 %h", valids, sb_pending, out_decoded, d);
    end
    tick();
    vectors++;
    if (valids !== 4'b0) begin miscompares++; $display("FAIL alu_handoff: valids=%b required 0000", valids); end
    wb(4'd1);
    vectors++;
    if (sb_pending !== 16'h0) begin miscompares++; $display("FAIL alu_wb: sb=%h required 0000", sb_pending); end
  endtask

  task automatic test_raw();
    send(mk(3'd0, 4'd0, 4'd1, 4'd2, 4'd3));
    in_valid = 1'b1; in_decoded = mk(3'd0, 4'd1, 4'd4, 4'd1, 4'd5);
    for (int i = 0; i < 3; i++) begin
      #1; vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall%0d: in_ready=%b required 0", i, in_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_index = 4'd1; #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_no_bypass: in_ready=%b required 0", in_ready); end
    tick(); wb_valid = 1'b0; #1;
    vectors++;
    if (in_ready !== 1'b1 || sb_pending !== 16'h0) begin
      miscompares++; $display("FAIL raw_release: in_ready=%b sb=%h required 1 0000", in_ready, sb_pending);
    end
    tick(); in_valid = 1'b0;
    vectors++;
    if (valids !== 4'b0001 || sb_pending !== 16'h0010) begin
      miscompares++; $display("FAIL raw_issue: valids=%b sb=%h required 0001 0010", valids, sb_pending);
    end
    tick(); wb(4'd4);
  endtask

  task automatic test_branch();
    send(mk(3'd1, 4'd0, 4'd2, 4'd0, 4'd0));
    vectors++;
    if (valids !== 4'b0010 || sb_pending !== 16'h0) begin
      miscompares++; $display("FAIL br_issue: valids=%b sb=%h required 0010 0000", valids, sb_pending);
    end
    in_valid = 1'b1; in_decoded = mk(3'd0, 4'd0, 4'd6, 4'd7, 4'd8);
    for (int i = 0; i < 5; i++) begin
      #1; vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL br_wait%0d: in_ready=%b required 0", i, in_ready); end
      tick();
    end
    br_done = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL br_done_cycle: in_ready=%b required 0", in_ready); end
    tick(); br_done = 1'b0; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL br_resume: in_ready=%b required 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++;
    if (valids !== 4'b0001 || sb_pending !== 16'h0040) begin
      miscompares++; $display("FAIL br_next_issue: valids=%b sb=%h required 0001 0040", valids, sb_pending);
    end
    tick(); wb(4'd6);
  endtask

  task automatic test_illegal();
    send(mk(3'd0, 4'd0, 4'd9, 4'd1, 4'd2));
    tick();
    send(mk(3'd5, 4'd0, 4'd1, 4'd2, 4'd3));
    vectors++;
    if (illegal !== 1'b1 || valids !== 4'b0 || sb_pending !== 16'h0200) begin
      miscompares++; $display("FAIL ill_group: ill=%b valids=%b sb=%h required 1 0000 0200", illegal, valids, sb_pending);
    end
    tick();
    vectors++;
    if (illegal !== 1'b0) begin miscompares++; $display("FAIL ill_pulse: ill=%b required 0", illegal); end
    send(mk(3'd0, 4'd13, 4'd1, 4'd2, 4'd3));
    vectors++;
    if (illegal !== 1'b1 || valids !== 4'b0 || sb_pending !== 16'h0200) begin
      miscompares++; $display("FAIL ill_oper: ill=%b valids=%b sb=%h required 1 0000 0200", illegal, valids, sb_pending);
    end
    send(mk(3'd0, 4'd0, 4'd3, 4'd1, 4'd2, 1'b1));
    vectors++;
    if (illegal !== 1'b0 || valids !== 4'b0 || sb_pending !== 16'h0200) begin
      miscompares++; $display("FAIL nop: ill=%b valids=%b sb=%h required 0 0000 0200", illegal, valids, sb_pending);
    end
    wb(4'd9);
  endtask

  task automatic test_mem_stall();
    decoded_t d = mk(3'd2, 4'd0, 4'd7, 4'd1, 4'd2);
    out_mem_ready = 1'b0;
    send(d);
    in_valid = 1'b1; in_decoded = mk(3'd0, 4'd0, 4'd8, 4'd1, 4'd2);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (valids !== 4'b0100 || out_decoded !== d || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL mem_hold%0d: valids=%b dec=%h rdy=%b required 0100 %h 0", i, valids, out_decoded, in_ready, d);
      end
      tick();
    end
    in_valid = 1'b0; out_mem_ready = 1'b1; tick();
    vectors++;
    if (valids !== 4'b0 || sb_pending !== 16'h0080) begin
      miscompares++; $display("FAIL mem_handoff: valids=%b sb=%h required 0000 0080", valids, sb_pending);
    end
    wb(4'd7);
    wb_valid = 1'b1; wb_index = 4'd7;
    send(mk(3'd4, 4'd0, 4'd7, 4'd3, 4'd0));
    wb_valid = 1'b0;
    vectors++;
    if (sb_pending !== 16'h0080 || valids !== 4'b1000) begin
      miscompares++; $display("FAIL wb_set_collide: sb=%h valids=%b required 0080 1000", sb_pending, valids);
    end
    tick(); wb(4'd7);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_decoded = mk(3'd0, 4'd5, 4'(10 + i), 4'd1, 4'd2); #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b%0d: in_ready=%b required 1", i, in_ready); end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (sb_pending !== 16'h3c00 || valids !== 4'b0001) begin
      miscompares++; $display("FAIL b2b_state: sb=%h valids=%b required 3c00 0001", sb_pending, valids);
    end
    tick();
    for (int i = 0; i < 4; i++) wb(4'(10 + i));
    vectors++;
    if (sb_pending !== 16'h0) begin miscompares++; $display("FAIL b2b_clear: sb=%h required 0000", sb_pending); end
  endtask

  task automatic test_reset_mid();
    send(mk(3'd0, 4'd0, 4'd5, 4'd1, 4'd2));
    tick();
    out_cf_ready = 1'b0;
    send(mk(3'd1, 4'd2, 4'd3, 4'd0, 4'd0));
    tick();
    vectors++;
    if (valids !== 4'b0010 || sb_pending !== 16'h0020) begin
      miscompares++; $display("FAIL mid_setup: valids=%b sb=%h required 0010 0020", valids, sb_pending);
    end
    rst = 1'b1; tick();
    exp_q.delete();
    vectors++;
    if (valids !== 4'b0 || sb_pending !== 16'h0 || out_decoded !== '0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: valids=%b sb=%h dec=%h rdy=%b required 0 0 0 0", valids, sb_pending, out_decoded, in_ready);
    end
    rst = 1'b0; out_cf_ready = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_resume: in_ready=%b required 1", in_ready); end
    send(mk(3'd0, 4'd0, 4'd1, 4'd2, 4'd3));
    vectors++;
    if (valids !== 4'b0001) begin miscompares++; $display("FAIL mid_issue: valids=%b required 0001", valids); end
    tick(); wb(4'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_decoded = '0; wb_valid = 1'b0; wb_index = 4'd0; br_done = 1'b0;
    out_alu_ready = 1'b1; out_cf_ready = 1'b1; out_mem_ready = 1'b1; out_io_ready = 1'b1;
    test_reset();
    test_alu();
    test_raw();
    test_branch();
    test_illegal();
    test_mem_stall();
    test_back_to_back();
    test_reset_mid();
    tick(); tick();
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain: %0d pending issues required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/snow64_issue_scheduler.md
# snow64_issue_scheduler

Single-issue scheduler between the Snow64 instruction decoder and the execution units. Accepts one decoded instruction per cycle and tracks register write-after/read-after hazards in a 16-entry scoreboard. Routes each instruction to the ALU, control-flow, memory or port-I/O unit over valid/ready handshakes, and holds issue while a branch is unresolved.

## Interface
Parameters:
- NUM_REGS, 16, architectural registers tracked; equals 2^(REG_INDEX width 4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  scheduler accepts this cycle
- in_decoded  in  85  decoder output struct: group 3, op_type 1, ra/rb/rc 4 each, oper 4, signext_imm 64, nop 1
- out_decoded  out  85  registered instruction presented to units
- out_alu_valid / out_alu_ready  out/in  1/1  group 0 handshake
- out_cf_valid / out_cf_ready  out/in  1/1  group 1 handshake
- out_mem_valid / out_mem_ready  out/in  1/1  groups 2 and 3 handshake
- out_io_valid / out_io_ready  out/in  1/1  group 4 handshake
- wb_valid  in  1  a unit writes register wb_index this cycle
- wb_index  in  4  written register
- br_done  in  1  pulse: pending branch resolved
- illegal  out  1  one-cycle pulse: undecodable instruction dropped
- sb_pending  out  16  scoreboard, bit n = write to rn outstanding

## Operation
- Register usage, derived from group/oper:
  - Group 0: dest ra; sources rb, rc. Inv/Not use rb only. Add_OneRegOnePcOneSimm12 has no sources.
  - Group 1: Btru/Bfal/Jmp use source ra. Cpy_OneRegOne{Ie,Ireta,Idsta} use dest ra. Cpy_One{Ie,Ireta,Idsta}OneReg use source ra. Ei/Di/Reti use no registers.
  - Group 2: dest ra; sources rb, rc.
  - Group 3: sources ra, rb, rc.
  - Group 4: In* dest ra, source rb. Out uses sources ra, rb.
- Illegal: groups 5–7, or any Bad*_Iog* oper.
- Hazard: any source or the dest has its sb_pending bit set. There is no bypass from wb_valid in the same cycle.
- in_ready = state RUN && no hazard && (output slot empty || slot handed off this cycle).
- On accept:
  - nop=1: consumed, no issue, no scoreboard change.
  - illegal: consumed, illegal=1 next cycle, no issue.
  - Otherwise: load output slot, set the dest bit.
  - Btru/Bfal/Jmp/Reti: state goes to BR_WAIT.
- FSM: RUN -> BR_WAIT on branch accept; BR_WAIT -> RUN on br_done. br_done in RUN is ignored.
- Scoreboard update per cycle: the wb_valid clear is applied first, then the accept set. If both hit the same index, the bit ends up set.
- wb_valid on an index whose bit is clear: no effect.

## Timing
- Reset: in_ready=0 during rst. After reset: all out_*_valid=0, out_decoded=0, illegal=0, sb_pending=0, state RUN. Any in-flight output is discarded.
- Latency: accept at cycle N -> out_*_valid high at N+1. Exactly one out_*_valid is high at a time, selected by the held group.
- Output is held stable until the matching ready; valid never drops without a handshake.
- Back-to-back throughput is 1/cycle when ready stays high and there are no hazards.
- RAW on a just-issued dest: earliest re-accept is the cycle after the wb_valid for that register.
- Branch: the next instruction is accepted no earlier than the cycle after br_done.
- rst asserted mid-BR_WAIT or mid-handshake: state returns to RUN and all outputs go to reset values on the next edge.

## Structure
- Add to PkgSnow64InstrDecoder:
  - IssueUnit enum (UnitAlu, UnitCf, UnitMem, UnitIo).
  - SchedState enum (StRun, StBrWait).
  - RegUsage struct (uses_ra_src, uses_rb, uses_rc, writes_ra, is_branch, illegal).
- Sub-module snow64_reg_usage_decode: purely combinational group/oper -> RegUsage.
- Scheduler top holds the scoreboard, output slot register and FSM.

## Test plan
- Reset, then Add r1,r2,r3 with alu_ready=1 -> out_alu_valid at N+1, sb_pending=16'h0002.
- Add r1,… then Sub r4,r1,r5 -> in_ready=0 until the cycle after wb_valid/wb_index=1; Sub issues the following cycle.
- Btru r2 accepted, next instr valid -> in_ready=0 for 5 cycles; br_done pulse -> accept on the following cycle.
- in_decoded group=3'b101 -> accepted, illegal=1 for one cycle, no out_*_valid, sb_pending unchanged.
- LdU8 r7 with mem_ready=0 for 3 cycles -> out_decoded stable, out_mem_valid held; a same-cycle wb_valid r7 with a new In r7 accept leaves bit7=1.
- rst asserted in BR_WAIT with out_cf_valid=1 -> next cycle all valids 0, sb_pending=0, in_ready=1 once rst drops.
